// File: rtl/filter_stream_responder_pkg.sv
// Shared accelerator constants, channel state encoding and filter address helper
// for the filter/input stream responder.
package filter_stream_responder_pkg;

  localparam int F          = 4;
  localparam int DW         = 16;
  localparam int AW         = 12;
  localparam int NUM_LAYERS = 4;
  localparam int KW         = 6;
  localparam int CW         = 12;
  localparam int LW         = $clog2(NUM_LAYERS);
  localparam int BW         = F * DW;

  typedef logic [1:0] chan_state_t;

  localparam chan_state_t CH_IDLE   = 2'd0;
  localparam chan_state_t CH_STREAM = 2'd1;
  localparam chan_state_t CH_DONE   = 2'd2;

  // Start of filter group k: base + k*beats, wrapping inside the AW-bit buffer.
  function automatic logic [AW-1:0] filt_start_addr(
    input logic [AW-1:0] base,
    input logic [KW-1:0] k,
    input logic [CW-1:0] beats
  );
    logic [KW+CW-1:0] prod;
    prod = (KW+CW)'(k) * (KW+CW)'(beats);
    return base + prod[AW-1:0];
  endfunction

endpackage

// File: rtl/filter_stream_responder_stream_rd_chan.sv
// One read-and-stream channel: walks a buffer region, keeps at most two beats
// outstanding, and presents them through a 2-entry FIFO with valid/ready.
module stream_rd_chan
  import filter_stream_responder_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic [AW-1:0] start_addr_i,
  input  logic [CW-1:0] beats_i,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [BW-1:0] rd_data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [BW-1:0] data_o,
  output logic          last_o,
  output logic          finish_o
);

  chan_state_t   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] beats_q, beats_d;
  logic [CW-1:0] iss_cnt_q, iss_cnt_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;
  logic [1:0]    credit_q, credit_d;
  logic          pend_q, pend_d;
  logic [BW-1:0] fifo_mem_q [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    fcnt_q, fcnt_d;

  logic          streaming;
  logic          xfer;
  logic          last_beat;
  logic          fifo_wr;
  logic [1:0]    credit_after;

  assign streaming    = (state_q == CH_STREAM) && req_i;
  assign valid_o      = (fcnt_q != 2'd0);
  assign xfer         = valid_o && ready_i;
  assign last_beat    = (acc_cnt_q == beats_q - CW'(1));
  // A beat accepted this cycle frees its credit for a read in the same cycle.
  assign credit_after = credit_q - 2'(xfer);
  assign rd_en_o      = streaming && (iss_cnt_q != beats_q) && (credit_after < 2'd2);
  assign rd_addr_o    = addr_q;
  assign fifo_wr      = pend_q && streaming;
  assign data_o       = valid_o ? fifo_mem_q[rd_ptr_q] : '0;
  assign last_o       = valid_o && last_beat;
  assign finish_o     = (state_q == CH_DONE) && req_i;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beats_d   = beats_q;
    iss_cnt_d = iss_cnt_q;
    acc_cnt_d = acc_cnt_q;
    credit_d  = credit_q;
    pend_d    = rd_en_o;
    case (state_q)
      CH_IDLE: begin
        if (req_i) begin
          addr_d    = start_addr_i;
          beats_d   = beats_i;
          iss_cnt_d = '0;
          acc_cnt_d = '0;
          credit_d  = '0;
          state_d   = (beats_i == '0) ? CH_DONE : CH_STREAM;
        end
      end
      CH_STREAM: begin
        if (!req_i) begin
          state_d  = CH_IDLE;
          credit_d = '0;
        end else begin
          if (rd_en_o) begin
            addr_d    = addr_q + AW'(1);
            iss_cnt_d = iss_cnt_q + CW'(1);
          end
          if (xfer) begin
            acc_cnt_d = acc_cnt_q + CW'(1);
            if (last_beat) begin
              state_d = CH_DONE;
            end
          end
          credit_d = credit_after + 2'(rd_en_o);
        end
      end
      CH_DONE: begin
        if (!req_i) begin
          state_d = CH_IDLE;
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  // Leaving STREAM (abort or completion) empties the FIFO and drops any late read data.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (!streaming) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      fcnt_d   = 2'd0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (xfer) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      fcnt_d = fcnt_q + 2'(fifo_wr) - 2'(xfer);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CH_IDLE;
      addr_q    <= '0;
      beats_q   <= '0;
      iss_cnt_q <= '0;
      acc_cnt_q <= '0;
      credit_q  <= '0;
      pend_q    <= 1'b0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      beats_q   <= beats_d;
      iss_cnt_q <= iss_cnt_d;
      acc_cnt_q <= acc_cnt_d;
      credit_q  <= credit_d;
      pend_q    <= pend_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fcnt_q    <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem_q[wr_ptr_q] <= rd_data_i;
    end
  end

endmodule

// File: rtl/filter_stream_responder.sv
// Serves filter-group and input-activation streams to a PE from two buffers,
// using one independent read channel per stream.
module filter_stream_responder
  import filter_stream_responder_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_filter_valid,
  input  logic [KW-1:0]            req_filter_k,
  input  logic [LW-1:0]            req_layer,
  input  logic                     req_input_valid,
  input  logic [NUM_LAYERS*AW-1:0] cfg_filt_base,
  input  logic [NUM_LAYERS*CW-1:0] cfg_filt_beats,
  input  logic [AW-1:0]            cfg_in_base,
  input  logic [CW-1:0]            cfg_in_beats,
  output logic                     fmem_rd_en,
  output logic [AW-1:0]            fmem_rd_addr,
  input  logic [BW-1:0]            fmem_rd_data,
  output logic                     imem_rd_en,
  output logic [AW-1:0]            imem_rd_addr,
  input  logic [BW-1:0]            imem_rd_data,
  output logic                     filt_valid,
  input  logic                     filt_ready,
  output logic [BW-1:0]            filt_data,
  output logic                     filt_last,
  output logic                     in_valid,
  input  logic                     in_ready,
  output logic [BW-1:0]            in_data,
  output logic                     in_last,
  output logic                     filter_finish,
  output logic                     input_finish
);

  logic [AW-1:0] filt_base_arr  [NUM_LAYERS];
  logic [CW-1:0] filt_beats_arr [NUM_LAYERS];
  logic [CW-1:0] filt_beats;
  logic [AW-1:0] filt_start;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer_cfg
      assign filt_base_arr[gi]  = cfg_filt_base[gi*AW +: AW];
      assign filt_beats_arr[gi] = cfg_filt_beats[gi*CW +: CW];
    end
  endgenerate

  assign filt_beats = filt_beats_arr[req_layer];
  assign filt_start = filt_start_addr(filt_base_arr[req_layer], req_filter_k, filt_beats);

  stream_rd_chan u_filt_chan (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_filter_valid),
    .start_addr_i (filt_start),
    .beats_i      (filt_beats),
    .rd_en_o      (fmem_rd_en),
    .rd_addr_o    (fmem_rd_addr),
    .rd_data_i    (fmem_rd_data),
    .valid_o      (filt_valid),
    .ready_i      (filt_ready),
    .data_o       (filt_data),
    .last_o       (filt_last),
    .finish_o     (filter_finish)
  );

  stream_rd_chan u_in_chan (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_input_valid),
    .start_addr_i (cfg_in_base),
    .beats_i      (cfg_in_beats),
    .rd_en_o      (imem_rd_en),
    .rd_addr_o    (imem_rd_addr),
    .rd_data_i    (imem_rd_data),
    .valid_o      (in_valid),
    .ready_i      (in_ready),
    .data_o       (in_data),
    .last_o       (in_last),
    .finish_o     (input_finish)
  );

endmodule

// File: tb/tb_filter_stream_responder.sv
// Directed bench for filter_stream_responder: buffer models return address-tagged
// data one cycle after each read; streams are checked beat by beat.
module tb_filter_stream_responder;
  import filter_stream_responder_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     req_filter_valid;
  logic [KW-1:0]            req_filter_k;
  logic [LW-1:0]            req_layer;
  logic                     req_input_valid;
  logic [NUM_LAYERS*AW-1:0] cfg_filt_base;
  logic [NUM_LAYERS*CW-1:0] cfg_filt_beats;
  logic [AW-1:0]            cfg_in_base;
  logic [CW-1:0]            cfg_in_beats;
  logic                     fmem_rd_en;
  logic [AW-1:0]            fmem_rd_addr;
  logic [BW-1:0]            fmem_rd_data;
  logic                     imem_rd_en;
  logic [AW-1:0]            imem_rd_addr;
  logic [BW-1:0]            imem_rd_data;
  logic                     filt_valid;
  logic                     filt_ready;
  logic [BW-1:0]            filt_data;
  logic                     filt_last;
  logic                     in_valid;
  logic                     in_ready;
  logic [BW-1:0]            in_data;
  logic                     in_last;
  logic                     filter_finish;
  logic                     input_finish;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [AW-1:0] f_addr_q[$];
  logic [AW-1:0] i_addr_q[$];
  logic [BW-1:0] f_data_q[$];
  logic [BW-1:0] i_data_q[$];
  logic          f_last_q[$];
  logic          i_last_q[$];
  int            f_cyc_q[$];
  int            i_cyc_q[$];

  logic          in_chk_en = 1'b0;
  int            i_out = 0;
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [BW-1:0] pd = '0;

  logic [11:0] outs_nz;
  assign outs_nz = {fmem_rd_en, |fmem_rd_addr, imem_rd_en, |imem_rd_addr,
                    filt_valid, |filt_data, filt_last, in_valid, |in_data, in_last,
                    filter_finish, input_finish};

  filter_stream_responder dut (
    .clk              (clk),
    .rst              (rst),
    .req_filter_valid (req_filter_valid),
    .req_filter_k     (req_filter_k),
    .req_layer        (req_layer),
    .req_input_valid  (req_input_valid),
    .cfg_filt_base    (cfg_filt_base),
    .cfg_filt_beats   (cfg_filt_beats),
    .cfg_in_base      (cfg_in_base),
    .cfg_in_beats     (cfg_in_beats),
    .fmem_rd_en       (fmem_rd_en),
    .fmem_rd_addr     (fmem_rd_addr),
    .fmem_rd_data     (fmem_rd_data),
    .imem_rd_en       (imem_rd_en),
    .imem_rd_addr     (imem_rd_addr),
    .imem_rd_data     (imem_rd_data),
    .filt_valid       (filt_valid),
    .filt_ready       (filt_ready),
    .filt_data        (filt_data),
    .filt_last        (filt_last),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_last          (in_last),
    .filter_finish    (filter_finish),
    .input_finish     (input_finish)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BW-1:0] fpat(input logic [AW-1:0] a);
    return {4'hA, a, 4'hB, a, 4'hC, a, 4'hD, a};
  endfunction

  function automatic logic [BW-1:0] ipat(input logic [AW-1:0] a);
    return {4'h1, a, 4'h2, a, 4'h3, a, 4'h4, a};
  endfunction

  always @(posedge clk) begin
    if (fmem_rd_en) fmem_rd_data <= fpat(fmem_rd_addr);
    if (imem_rd_en) imem_rd_data <= ipat(imem_rd_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  // Transfer/read recorder plus stall and credit checks for the input channel.
  always @(negedge clk) begin
    int nxt;
    if (filt_valid && filt_ready) begin
      f_data_q.push_back(filt_data);
      f_last_q.push_back(filt_last);
      f_cyc_q.push_back(cyc);
      $display("beat filt data=%h last=%0b cyc=%0d", filt_data, filt_last, cyc);
    end
    if (in_valid && in_ready) begin
      i_data_q.push_back(in_data);
      i_last_q.push_back(in_last);
      i_cyc_q.push_back(cyc);
      $display("beat in   data=%h last=%0b cyc=%0d", in_data, in_last, cyc);
    end
    if (fmem_rd_en) f_addr_q.push_back(fmem_rd_addr);
    if (imem_rd_en) i_addr_q.push_back(imem_rd_addr);
    if (in_chk_en) begin
      nxt = i_out + int'(imem_rd_en) - int'(in_valid && in_ready);
      chk("t2_outst_le2", 64'(nxt <= 2), 64'd1);
      if (pv && !pr) begin
        chk("t2_hold_valid", 64'(in_valid), 64'd1);
        chk("t2_hold_data", 64'(in_data), 64'(pd));
      end
      i_out <= nxt;
    end else begin
      i_out <= 0;
    end
    pv <= in_valid;
    pr <= in_ready;
    pd <= in_data;
  end

  task automatic clear_queues();
    f_addr_q.delete(); f_data_q.delete(); f_last_q.delete(); f_cyc_q.delete();
    i_addr_q.delete(); i_data_q.delete(); i_last_q.delete(); i_cyc_q.delete();
  endtask

  // Compare a recorded stream against start..start+n-1; first_cyc < 0 skips timing.
  task automatic check_stream(input string tag, input bit is_filt, input logic [AW-1:0] start,
                              input int n, input int first_cyc);
    logic [AW-1:0] aq[$];
    logic [BW-1:0] dq[$];
    logic          lq[$];
    int            cq[$];
    logic [AW-1:0] ea;
    if (is_filt) begin
      aq = f_addr_q; dq = f_data_q; lq = f_last_q; cq = f_cyc_q;
    end else begin
      aq = i_addr_q; dq = i_data_q; lq = i_last_q; cq = i_cyc_q;
    end
    chk({tag, "_nbeats"}, 64'(dq.size()), 64'(n));
    chk({tag, "_nreads"}, 64'(aq.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      ea = start + AW'(i);
      if (i < aq.size()) chk({tag, "_addr"}, 64'(aq[i]), 64'(ea));
      if (i < dq.size()) begin
        chk({tag, "_data"}, 64'(dq[i]), is_filt ? 64'(fpat(ea)) : 64'(ipat(ea)));
        chk({tag, "_last"}, 64'(lq[i]), 64'(i == n - 1));
        if (first_cyc >= 0) chk({tag, "_beat_cyc"}, 64'(cq[i]), 64'(first_cyc + i));
      end
    end
  endtask

  task automatic filt_run(input string tag, input logic [LW-1:0] layer, input logic [KW-1:0] k,
                          input logic [AW-1:0] start, input int n);
    int req_cyc;
    int fin_cyc;
    bit done;
    @(posedge clk); #1;
    clear_queues();
    req_layer        = layer;
    req_filter_k     = k;
    filt_ready       = 1'b1;
    req_filter_valid = 1'b1;
    req_cyc = cyc + 1;
    done    = 1'b0;
    fin_cyc = 0;
    for (int i = 0; i < n + 20 && !done; i++) begin
      @(negedge clk);
      if (filter_finish) begin
        done    = 1'b1;
        fin_cyc = cyc;
      end
    end
    chk({tag, "_finish_seen"}, 64'(done), 64'd1);
    check_stream(tag, 1'b1, start, n, req_cyc + 2);
    chk({tag, "_finish_cyc"}, 64'(fin_cyc), 64'(req_cyc + 2 + n));
    @(negedge clk);
    chk({tag, "_finish_hold"}, 64'(filter_finish), 64'd1);
    @(posedge clk); #1;
    req_filter_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_finish_drop"}, 64'(filter_finish), 64'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit done;
    rst              = 1'b1;
    req_filter_valid = 1'b0;
    req_filter_k     = '0;
    req_layer        = '0;
    req_input_valid  = 1'b0;
    cfg_filt_base    = {12'h300, 12'h200, 12'h100, 12'hFFE};
    cfg_filt_beats   = {12'd10, 12'd5, 12'd8, 12'd4};
    cfg_in_base      = 12'h040;
    cfg_in_beats     = 12'd6;
    filt_ready       = 1'b0;
    in_ready         = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs_zero", 64'(outs_nz), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Layer 1, k=2: 0x100 + 2*8 = 0x110, eight beats.
    filt_run("t1", 2'd1, 6'd2, 12'h110, 8);

    // Input channel, ready toggling every cycle.
    @(posedge clk); #1;
    clear_queues();
    cfg_in_base     = 12'h040;
    cfg_in_beats    = 12'd6;
    in_ready        = 1'b1;
    in_chk_en       = 1'b1;
    req_input_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      in_ready = ~in_ready;
      @(negedge clk);
      if (input_finish) done = 1'b1;
    end
    in_chk_en = 1'b0;
    chk("t2_finish_seen", 64'(done), 64'd1);
    check_stream("t2", 1'b0, 12'h040, 6, -1);
    @(posedge clk); #1;
    req_input_valid = 1'b0;
    in_ready        = 1'b0;
    @(negedge clk);
    chk("t2_finish_drop", 64'(input_finish), 64'd0);
    repeat (2) @(posedge clk);

    // Layer 0 base 0xFFE wraps through the top of the buffer.
    filt_run("t3", 2'd0, 6'd0, 12'hFFE, 4);

    // Both channels, five beats each, launched together.
    @(posedge clk); #1;
    clear_queues();
    cfg_in_base      = 12'h080;
    cfg_in_beats     = 12'd5;
    req_layer        = 2'd2;
    req_filter_k     = 6'd0;
    filt_ready       = 1'b1;
    in_ready         = 1'b1;
    req_filter_valid = 1'b1;
    req_input_valid  = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (filter_finish || input_finish) done = 1'b1;
    end
    chk("t4_both_finish", 64'({filter_finish, input_finish}), 64'd3);
    check_stream("t4f", 1'b1, 12'h200, 5, -1);
    check_stream("t4i", 1'b0, 12'h080, 5, -1);
    repeat (3) begin
      @(negedge clk);
      chk("t4_finish_hold", 64'({filter_finish, input_finish}), 64'd3);
    end
    @(posedge clk); #1;
    req_filter_valid = 1'b0;
    req_input_valid  = 1'b0;
    @(negedge clk);
    chk("t4_finish_drop", 64'({filter_finish, input_finish}), 64'd0);
    repeat (2) @(posedge clk);

    // Layer 3, k=1: start 0x30A of 10 beats, request dropped after beat 3.
    @(posedge clk); #1;
    clear_queues();
    req_layer        = 2'd3;
    req_filter_k     = 6'd1;
    filt_ready       = 1'b1;
    req_filter_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 3; i++) begin
      @(negedge clk);
      if (filt_valid && filt_ready) cnt++;
    end
    @(posedge clk); #1;
    req_filter_valid = 1'b0;
    filt_ready       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_valid_low", 64'(filt_valid), 64'd0);
    chk("t5_rd_en_low", 64'(fmem_rd_en), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_finish", 64'(filter_finish), 64'd0);
    end
    chk("t5_nbeats", 64'(f_data_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < f_data_q.size()) chk("t5_data", 64'(f_data_q[i]), 64'(fpat(12'h30A + AW'(i))));
    end
    filt_run("t5_new", 2'd1, 6'd0, 12'h100, 8);

    // Reset with both streams mid-flight and both requests still high.
    @(posedge clk); #1;
    clear_queues();
    cfg_in_base      = 12'h080;
    cfg_in_beats     = 12'd5;
    req_layer        = 2'd1;
    req_filter_k     = 6'd2;
    filt_ready       = 1'b1;
    in_ready         = 1'b1;
    req_filter_valid = 1'b1;
    req_input_valid  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_pre_valid", 64'(filt_valid && in_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_outputs_zero", 64'(outs_nz), 64'd0);
    @(posedge clk); #1;
    req_filter_valid = 1'b0;
    req_input_valid  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    filt_run("t6", 2'd1, 6'd2, 12'h110, 8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
